// File: rtl/serial_rx7_loader.sv
// serial_rx7_loader: deserialises a framed async serial line (start, 7 data bits LSB first,
// optional even parity, stop) and presents the word on data with a one-cycle load strobe.
// Define SERIAL_RX7_PARITY_EN to insert an even-parity bit between bit 6 and the stop bit.
module serial_rx7_loader #(
   parameter int unsigned BIT_TICKS = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [6:0] data,
   output logic       load,
   output logic       frame_err,
   output logic       busy
);

   localparam int unsigned TW = (BIT_TICKS > 2) ? $clog2(BIT_TICKS) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICKS - 1);
   localparam logic [TW-1:0] TICK_HALF = TW'(BIT_TICKS / 2 - 1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

   state_e          state_q, state_d;
   logic [TW-1:0]   tick_q, tick_d;
   logic [2:0]      idx_q, idx_d;
   logic [6:0]      shift_q, shift_d;
   logic [6:0]      data_q, data_d;
   logic            load_q, load_d;
   logic            ferr_q, ferr_d;
   logic            rx_meta_q, rx_s_q;
   logic            parity_ok;
`ifdef SERIAL_RX7_PARITY_EN
   logic            par_q, par_d;
`endif

   // Two-flop synchroniser; idles high so reset never looks like a start bit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         tick_q  <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         load_q  <= 1'b0;
         ferr_q  <= 1'b0;
`ifdef SERIAL_RX7_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         load_q  <= load_d;
         ferr_q  <= ferr_d;
`ifdef SERIAL_RX7_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

`ifdef SERIAL_RX7_PARITY_EN
   // Even parity over data bits plus the parity bit.
   assign parity_ok = ~(^shift_q ^ par_q);
`else
   assign parity_ok = 1'b1;
`endif

   // Next-state: bit timing, sampling and strobe generation.
   always_comb begin
      state_d = state_q;
      tick_d  = tick_q + 1'b1;
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      load_d  = 1'b0;
      ferr_d  = 1'b0;
`ifdef SERIAL_RX7_PARITY_EN
      par_d   = par_q;
`endif
      unique case (state_q)
         StIdle: begin
            tick_d = '0;
            if (!rx_s_q) begin
               state_d = StStart;
            end
         end
         StStart: begin
            if (tick_q == TICK_HALF) begin
               tick_d = '0;
               if (rx_s_q) begin
                  state_d = StIdle;  // glitch, not a real start bit
               end else begin
                  state_d = StData;
                  idx_d   = '0;
               end
            end
         end
         StData: begin
            if (tick_q == TICK_LAST) begin
               tick_d          = '0;
               shift_d[idx_q]  = rx_s_q;
               if (idx_q == 3'd6) begin
`ifdef SERIAL_RX7_PARITY_EN
                  state_d = StParity;
`else
                  state_d = StStop;
`endif
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
`ifdef SERIAL_RX7_PARITY_EN
         StParity: begin
            if (tick_q == TICK_LAST) begin
               tick_d  = '0;
               par_d   = rx_s_q;
               state_d = StStop;
            end
         end
`endif
         StStop: begin
            if (tick_q == TICK_LAST) begin
               tick_d  = '0;
               state_d = StIdle;
               if (rx_s_q && parity_ok) begin
                  data_d = shift_q;
                  load_d = 1'b1;
               end else begin
                  ferr_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = StIdle;
            tick_d  = '0;
         end
      endcase
   end

   // Outputs: strobes are registered, busy decodes the state.
   always_comb begin
      busy      = (state_q != StIdle);
      data      = data_q;
      load      = load_q;
      frame_err = ferr_q;
   end

endmodule
